// File: rtl/mac_engine_multilane.sv
// ============================================================================
// Module      : mac_engine_multilane
// Description : NB_LANES parallel signed MAC lanes with simple-multiply and
//               scalar-product modes; optional output saturation enabled by
//               the MAC_ENGINE_SAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_engine_multilane #(
    parameter int DW       = 32,
    parameter int NB_LANES = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic                   simple_mul_i,
    input  logic [CNT_W-1:0]       len_i,
    input  logic [5:0]             shift_i,
    input  logic                   round_i,
    input  logic [NB_LANES*DW-1:0] a_i_data,
    input  logic                   a_i_valid,
    output logic                   a_i_ready,
    input  logic [NB_LANES*DW-1:0] b_i_data,
    input  logic                   b_i_valid,
    output logic                   b_i_ready,
    input  logic [NB_LANES*DW-1:0] c_i_data,
    input  logic                   c_i_valid,
    output logic                   c_i_ready,
    output logic [NB_LANES*DW-1:0] d_o_data,
    output logic [NB_LANES*DW/8-1:0] d_o_strb,
    output logic                   d_o_valid,
    input  logic                   d_o_ready,
    output logic [CNT_W-1:0]       cnt_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sat_o
);

    localparam int c_PW = 2 * DW;
    localparam int c_AW = 2 * DW + CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        ACCUM   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_mult_valid;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_issued;
    logic [5:0]       r_shift;

    logic       w_run;
    logic       w_ab_ready;
    logic       w_ab_hs;
    logic       w_c_hs;
    logic       w_d_hs;
    logic       w_acc_en;
    logic       w_mult_pop;
    logic [5:0] w_shift;

    assign w_run = enable_i && !clear_i;

    always_comb begin
        w_ab_ready = 1'b0;
        if (w_run && a_i_valid && b_i_valid) begin
            case (r_state)
                IDLE:    w_ab_ready = simple_mul_i && (!r_mult_valid || d_o_ready);
                ACCUM:   w_ab_ready = (r_issued != r_len);
                default: w_ab_ready = 1'b0;
            endcase
        end
    end

    assign a_i_ready  = w_ab_ready;
    assign b_i_ready  = w_ab_ready;
    assign w_ab_hs    = w_ab_ready;
    assign c_i_ready  = w_run && (r_state == PRELOAD);
    assign w_c_hs     = c_i_ready && c_i_valid;
    assign d_o_valid  = w_run && (((r_state == IDLE) && r_mult_valid) || (r_state == DRAIN));
    assign d_o_strb   = '1;
    assign w_d_hs     = d_o_valid && d_o_ready;
    assign done_o     = w_d_hs && (r_state == DRAIN);
    assign busy_o     = (r_state != IDLE);
    assign cnt_o      = r_cnt;
    // In ACCUM the product register drains into the accumulators every cycle.
    assign w_acc_en   = (r_state == ACCUM) && r_mult_valid;
    assign w_mult_pop = ((r_state == IDLE) && w_d_hs) || w_acc_en;
    assign w_shift    = (r_state == DRAIN) ? r_shift : shift_i;

    logic [NB_LANES-1:0] w_clip;

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        logic signed [c_PW-1:0] r_mult;
        logic signed [c_AW-1:0] r_acc;
        logic signed [c_PW-1:0] w_prod;
        logic signed [c_AW-1:0] w_mult_ext;
        logic signed [c_AW-1:0] w_c_ext;
        logic signed [c_AW-1:0] w_val;
        logic signed [c_AW-1:0] w_rnd;
        logic signed [c_AW-1:0] w_sum;

        assign w_prod     = $signed(a_i_data[k*DW +: DW]) * $signed(b_i_data[k*DW +: DW]);
        assign w_mult_ext = {{CNT_W{r_mult[c_PW-1]}}, r_mult};
        assign w_c_ext    = {{(c_AW-DW){c_i_data[k*DW+DW-1]}}, c_i_data[k*DW +: DW]};
        assign w_val      = (r_state == DRAIN) ? r_acc : w_mult_ext;
        assign w_rnd      = (round_i && (w_shift != 6'd0))
                          ? ({{(c_AW-1){1'b0}}, 1'b1} << (w_shift - 6'd1)) : '0;
        assign w_sum      = w_val + w_rnd;

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                r_mult <= '0;
                r_acc  <= '0;
            end else if (enable_i) begin
                if (w_ab_hs) r_mult <= w_prod;
                if (w_c_hs) r_acc <= w_c_ext <<< r_shift;
                else if (w_acc_en) r_acc <= r_acc + w_mult_ext;
            end
        end

`ifdef MAC_ENGINE_SAT_EN
        localparam logic signed [c_AW-1:0] c_MAX = {{(c_AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        localparam logic signed [c_AW-1:0] c_MIN = {{(c_AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        logic signed [c_AW-1:0] w_shr;
        logic                   w_hi;
        logic                   w_lo;

        assign w_shr     = w_sum >>> w_shift;
        assign w_hi      = (w_shr > c_MAX);
        assign w_lo      = (w_shr < c_MIN);
        assign w_clip[k] = w_hi || w_lo;
        assign d_o_data[k*DW +: DW] = w_hi ? {1'b0, {(DW-1){1'b1}}}
                                    : w_lo ? {1'b1, {(DW-1){1'b0}}}
                                    : w_shr[DW-1:0];
`else
        assign w_clip[k] = 1'b0;
        assign d_o_data[k*DW +: DW] = DW'(w_sum >>> w_shift);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state      <= IDLE;
            r_mult_valid <= 1'b0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_issued     <= '0;
            r_shift      <= '0;
        end else if (enable_i) begin
            if (w_ab_hs) r_mult_valid <= 1'b1;
            else if (w_mult_pop) r_mult_valid <= 1'b0;
            if (w_ab_hs && (r_state == ACCUM)) r_issued <= r_issued + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (start_i && !simple_mul_i && !r_mult_valid) begin
                        r_state  <= PRELOAD;
                        r_len    <= len_i;
                        r_shift  <= shift_i;
                        r_cnt    <= '0;
                        r_issued <= '0;
                    end
                end
                PRELOAD: begin
                    if (w_c_hs) r_state <= (r_len == '0) ? DRAIN : ACCUM;
                end
                ACCUM: begin
                    if (r_mult_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((r_cnt + CNT_W'(1)) == r_len) r_state <= DRAIN;
                    end
                end
                default: begin
                    if (w_d_hs) r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAC_ENGINE_SAT_EN
    logic r_sat;
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) r_sat <= 1'b0;
        else if (enable_i && w_d_hs && (|w_clip)) r_sat <= 1'b1;
    end
    assign sat_o = r_sat;
`else
    assign sat_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_engine_multilane.sv
// ============================================================================
// Module      : tb_mac_engine_multilane
// Description : Directed self-checking bench for mac_engine_multilane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_engine_multilane;

    localparam int c_W = 128;

    logic             clk_i = 1'b0;
    logic             rst_i, clear_i, enable_i, start_i, simple_mul_i, round_i;
    logic [15:0]      len_i;
    logic [5:0]       shift_i;
    logic [c_W-1:0]   a_i_data, b_i_data, c_i_data, d_o_data;
    logic             a_i_valid, a_i_ready, b_i_valid, b_i_ready, c_i_valid, c_i_ready;
    logic [15:0]      d_o_strb;
    logic             d_o_valid, d_o_ready;
    logic [15:0]      cnt_o;
    logic             busy_o, done_o, sat_o;

    int n_pass  = 0;
    int n_total = 0;

    mac_engine_multilane dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .start_i(start_i), .simple_mul_i(simple_mul_i), .len_i(len_i),
        .shift_i(shift_i), .round_i(round_i),
        .a_i_data(a_i_data), .a_i_valid(a_i_valid), .a_i_ready(a_i_ready),
        .b_i_data(b_i_data), .b_i_valid(b_i_valid), .b_i_ready(b_i_ready),
        .c_i_data(c_i_data), .c_i_valid(c_i_valid), .c_i_ready(c_i_ready),
        .d_o_data(d_o_data), .d_o_strb(d_o_strb), .d_o_valid(d_o_valid),
        .d_o_ready(d_o_ready), .cnt_o(cnt_o), .busy_o(busy_o), .done_o(done_o),
        .sat_o(sat_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sh;
        logic        rnd;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[11];

    function automatic logic [c_W-1:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    task automatic chk(input string nm, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // Called at edge+1; returns at edge+5 of the cycle where the ready is seen.
    task automatic wait_ready(input bit use_c, input string nm);
        int n = 0;
        settle();
        while (!(use_c ? c_i_ready : a_i_ready) && n < 20) begin
            @(posedge clk_i);
            #5;
            n++;
        end
        n_total++;
        if (use_c ? c_i_ready : a_i_ready) n_pass++;
        else $display("FAIL %s: got ready=0 expected ready=1 within 20 cycles", nm);
    endtask

    task automatic scalar(input int len, input logic [31:0] c, input int sh, input bit rnd,
                          input int base, input int inc, input logic [31:0] exp, input bit bp);
        simple_mul_i = 1'b0;
        start_i      = 1'b1;
        len_i        = 16'(len);
        shift_i      = 6'(sh);
        round_i      = rnd;
        tick();
        start_i = 1'b0;
        settle();
        chk("sp_busy_after_start", 128'(busy_o), 128'(1));
        chk("sp_cnt_after_start", 128'(cnt_o), 128'(0));
        tick();
        c_i_data  = rep(c);
        c_i_valid = 1'b1;
        wait_ready(1'b1, "sp_c_ready");
        tick();
        c_i_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            a_i_data  = rep(32'(base + i * inc));
            b_i_data  = rep(32'(base + i * inc));
            a_i_valid = 1'b1;
            b_i_valid = 1'b1;
            wait_ready(1'b0, "sp_ab_ready");
            tick();
        end
        // Keep offering operands: none may be taken once len products are in.
        a_i_data  = rep(32'd99);
        b_i_data  = rep(32'd99);
        a_i_valid = 1'b1;
        b_i_valid = 1'b1;
        if (len > 0) begin
            settle();
            chk("sp_ab_ready_after_len", 128'(a_i_ready), 128'(0));
            chk("sp_dvalid_1cyc", 128'(d_o_valid), 128'(0));
            tick();
        end
        settle();
        chk("sp_dvalid_2cyc", 128'(d_o_valid), 128'(1));
        chk("sp_data", d_o_data, rep(exp));
        chk("sp_cnt", 128'(cnt_o), 128'(len));
        chk("sp_ab_ready_drain", 128'(a_i_ready), 128'(0));
        if (bp) begin
            d_o_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                settle();
                chk("sp_bp_data", d_o_data, rep(exp));
                chk("sp_bp_valid", 128'(d_o_valid), 128'(1));
                chk("sp_bp_done", 128'(done_o), 128'(0));
            end
            d_o_ready = 1'b1;
            #0;
        end
        chk("sp_done", 128'(done_o), 128'(1));
        tick();
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        settle();
        chk("sp_idle_busy", 128'(busy_o), 128'(0));
        chk("sp_done_once", 128'(done_o), 128'(0));
        tick();
    endtask

    initial begin
        logic [c_W-1:0] exp_v;

        tv[0]  = '{32'd3,        32'hFFFFFFFB, 6'd0,  1'b0, 32'hFFFFFFF1};
        tv[1]  = '{32'd7,        32'd6,        6'd1,  1'b0, 32'd21};
        tv[2]  = '{32'd7,        32'd3,        6'd1,  1'b0, 32'd10};
        tv[3]  = '{32'd7,        32'd3,        6'd1,  1'b1, 32'd11};
        tv[4]  = '{32'hFFFFFFF9, 32'd3,        6'd2,  1'b1, 32'hFFFFFFFB};
        tv[5]  = '{32'hFFFFFFF9, 32'd3,        6'd2,  1'b0, 32'hFFFFFFFA};
        tv[6]  = '{32'h00010000, 32'h00010000, 6'd16, 1'b0, 32'h00010000};
        tv[7]  = '{32'd1000,     32'd3,        6'd4,  1'b1, 32'd188};
        tv[8]  = '{32'd1000,     32'd3,        6'd4,  1'b0, 32'd187};
        tv[9]  = '{32'h80000000, 32'd1,        6'd0,  1'b0, 32'h80000000};
`ifdef MAC_ENGINE_SAT_EN
        tv[10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 6'd0,  1'b0, 32'h7FFFFFFF};
`else
        tv[10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 6'd0,  1'b0, 32'h00000001};
`endif

        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
        simple_mul_i = 1'b1; round_i = 1'b0; len_i = '0; shift_i = '0;
        a_i_data = '0; b_i_data = '0; c_i_data = '0;
        a_i_valid = 1'b0; b_i_valid = 1'b0; c_i_valid = 1'b0; d_o_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_cnt", 128'(cnt_o), 128'(0));
        chk("rst_dvalid", 128'(d_o_valid), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_sat", 128'(sat_o), 128'(0));
        chk("strb", 128'(d_o_strb), 128'(16'hFFFF));
        tick();
        rst_i = 1'b0;

        // Simple-mode vector table
        for (int i = 0; i < 11; i++) begin
            simple_mul_i = 1'b1;
            a_i_data = rep(tv[i].a);
            b_i_data = rep(tv[i].b);
            shift_i  = tv[i].sh;
            round_i  = tv[i].rnd;
            a_i_valid = 1'b1;
            b_i_valid = 1'b1;
            settle();
            chk($sformatf("vec%0d_ab_ready", i), 128'(a_i_ready), 128'(1));
            tick();
            a_i_valid = 1'b0;
            b_i_valid = 1'b0;
            settle();
            chk($sformatf("vec%0d_dvalid", i), 128'(d_o_valid), 128'(1));
            chk($sformatf("vec%0d_data", i), d_o_data, rep(tv[i].exp));
            tick();
            if (i == 9) begin
                settle();
                chk("sat_before_clip", 128'(sat_o), 128'(0));
                tick();
            end
        end
        settle();
`ifdef MAC_ENGINE_SAT_EN
        chk("sat_after_clip", 128'(sat_o), 128'(1));
`else
        chk("sat_after_clip", 128'(sat_o), 128'(0));
`endif
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        settle();
        chk("sat_after_clear", 128'(sat_o), 128'(0));
        tick();

        // Enable low: nothing accepted, no output
        enable_i  = 1'b0;
        a_i_data  = rep(32'd4);
        b_i_data  = rep(32'd4);
        shift_i   = 6'd0;
        round_i   = 1'b0;
        a_i_valid = 1'b1;
        b_i_valid = 1'b1;
        settle();
        chk("en0_ab_ready", 128'(a_i_ready), 128'(0));
        tick();
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        enable_i  = 1'b1;
        settle();
        chk("en0_no_output", 128'(d_o_valid), 128'(0));
        tick();

        // Back-to-back simple mode, distinct lanes, no bubbles
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                for (int k = 0; k < 4; k++) begin
                    a_i_data[k*32 +: 32] = 32'(j + k);
                    b_i_data[k*32 +: 32] = 32'd3;
                end
                a_i_valid = 1'b1;
                b_i_valid = 1'b1;
            end else begin
                a_i_valid = 1'b0;
                b_i_valid = 1'b0;
            end
            settle();
            if (j < 8) chk($sformatf("b2b%0d_ab_ready", j), 128'(a_i_ready), 128'(1));
            if (j > 0) begin
                for (int k = 0; k < 4; k++) exp_v[k*32 +: 32] = 32'(3 * (j - 1 + k));
                chk($sformatf("b2b%0d_dvalid", j), 128'(d_o_valid), 128'(1));
                chk($sformatf("b2b%0d_data", j), d_o_data, exp_v);
            end
            tick();
        end
        settle();
        chk("b2b_drained", 128'(d_o_valid), 128'(0));
        tick();

        // Simple-mode backpressure
        d_o_ready = 1'b0;
        a_i_data  = rep(32'd5);
        b_i_data  = rep(32'd5);
        a_i_valid = 1'b1;
        b_i_valid = 1'b1;
        settle();
        chk("bp_first_ready", 128'(a_i_ready), 128'(1));
        tick();
        a_i_data = rep(32'd6);
        b_i_data = rep(32'd6);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_ab_blocked", 128'(a_i_ready), 128'(0));
            chk("bp_data_stable", d_o_data, rep(32'd25));
            tick();
        end
        d_o_ready = 1'b1;
        settle();
        chk("bp_release_ready", 128'(a_i_ready), 128'(1));
        tick();
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        settle();
        chk("bp_second_valid", 128'(d_o_valid), 128'(1));
        chk("bp_second_data", d_o_data, rep(32'd36));
        tick();
        settle();
        chk("bp_no_dup", 128'(d_o_valid), 128'(0));
        tick();

        // Scalar products
        scalar(4, 32'd10, 2, 1'b0, 1, 1, 32'd17, 1'b1);
        scalar(4, 32'd10, 2, 1'b1, 1, 1, 32'd18, 1'b0);
        scalar(0, 32'hFFFFFFF9, 3, 1'b0, 0, 0, 32'hFFFFFFF9, 1'b0);

        // Clear in the middle of a scalar product
        simple_mul_i = 1'b0;
        start_i      = 1'b1;
        len_i        = 16'd4;
        shift_i      = 6'd0;
        round_i      = 1'b0;
        tick();
        start_i   = 1'b0;
        c_i_data  = rep(32'd0);
        c_i_valid = 1'b1;
        wait_ready(1'b1, "clr_c_ready");
        tick();
        c_i_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_i_data  = rep(32'd3);
            b_i_data  = rep(32'd3);
            a_i_valid = 1'b1;
            b_i_valid = 1'b1;
            wait_ready(1'b0, "clr_ab_ready");
            tick();
        end
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        clear_i   = 1'b1;
        tick();
        clear_i = 1'b0;
        settle();
        chk("clr_busy", 128'(busy_o), 128'(0));
        chk("clr_cnt", 128'(cnt_o), 128'(0));
        chk("clr_dvalid", 128'(d_o_valid), 128'(0));
        tick();
        scalar(1, 32'd0, 0, 1'b0, 2, 0, 32'd4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_engine_multilane.md
MAC_ENGINE_MULTILANE -- requirements
Module: mac_engine_multilane

Interface
REQ-001 SHALL have parameter DW, default 32, per-lane operand width.
REQ-002 SHALL have parameter NB_LANES, default 4, number of independent MAC lanes.
REQ-003 SHALL have parameter CNT_W, default 16, width of the length counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have the following ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  soft clear
- enable_i  in  1  global enable
- start_i  in  1  start scalar product
- simple_mul_i  in  1  1 = simple multiply, 0 = scalar product
- len_i  in  CNT_W  products per scalar product
- shift_i  in  6  fixed-point shift
- round_i  in  1  round-to-nearest on output
- a_i  sink  NB_LANES*DW  HWPE-Stream operand A; lane k at bits [k*DW +: DW]
- b_i  sink  NB_LANES*DW  HWPE-Stream operand B
- c_i  sink  NB_LANES*DW  HWPE-Stream accumulator preload
- d_o  source  NB_LANES*DW  HWPE-Stream result; strb all ones
- cnt_o  out  CNT_W  products accumulated in the current scalar product
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle pulse on final d_o handshake of a scalar product
- sat_o  out  1  sticky saturation flag

Function
REQ-006 SHALL compute per lane: product = signed(a)*signed(b), 2*DW bits; accumulator 2*DW+CNT_W bits, sign-extended.
REQ-007 SHALL take a_i and b_i jointly: both readies asserted only when both valids are high and the product register can accept.
REQ-008 SHALL register products in r_mult (valid-tracked); r_mult valid SHALL drop only after its output handshake.
REQ-009 SHALL, in simple mode, drive d_o from r_mult: valid 1 cycle after the a/b handshake, fully pipelined at 1 beat/cycle under d_o.ready=1.
REQ-010 SHALL compute output = (value + R) >>> shift_i, with R = 1<<(shift_i-1) when round_i=1 and shift_i>0, else 0; result truncated to DW bits.
REQ-011 SHALL implement FSM IDLE -> PRELOAD -> ACCUM -> DRAIN -> IDLE for scalar-product mode.
REQ-012 SHALL leave IDLE on start_i=1 with simple_mul_i=0; latch len_i and shift_i; cnt_o=0.
REQ-013 SHALL ignore start_i outside IDLE.
REQ-014 SHALL accept exactly one c_i beat in PRELOAD: acc = sext(c) <<< shift; then go to ACCUM, or to DRAIN if latched len=0.
REQ-015 SHALL deassert c_i.ready outside PRELOAD, and a_i/b_i ready outside ACCUM in scalar mode.
REQ-016 SHALL add each r_mult handshake into acc and increment cnt_o; go to DRAIN when cnt reaches len.
REQ-017 SHALL stop accepting a/b in ACCUM once len products have entered r_mult.
REQ-018 SHALL assert d_o.valid in DRAIN exactly 2 cycles after the last a/b handshake, and hold data stable until d_o.ready.
REQ-019 SHALL pulse done_o and go to IDLE on the DRAIN handshake.
REQ-020 SHALL, while enable_i=0, freeze all state and force all readies and d_o.valid to 0.
REQ-021 SHALL, on clear_i=1 (any state), on the next edge zero all registers, set IDLE and cnt_o=0; clear_i has priority over start_i and handshakes.

Reset
REQ-022 SHALL, on rst_i=1 at a clock edge, set state IDLE and zero all data, valid, cnt_o, busy_o, done_o and sat_o.

Configuration
REQ-023 SHALL, with MAC_ENGINE_SAT_EN defined, clip each lane output to [-2^(DW-1), 2^(DW-1)-1] and set sat_o on any clip until clear or reset.
REQ-024 SHALL, without MAC_ENGINE_SAT_EN, truncate (wrap) the output and tie sat_o to 0.

Verification
REQ-025 SHALL test simple mode, all lanes a=3, b=-5, shift 0 -> d=-15 (0xFFFFFFF1) one cycle after the handshake; 8 back-to-back beats -> 8 outputs, no bubbles.
REQ-026 SHALL test scalar mode, len=4, c=10, shift=2, a=b=1,2,3,4: round 0 -> d=17; round 1 -> d=18; done_o pulses once; cnt_o=4.
REQ-027 SHALL test backpressure: d_o.ready=0 for 5 cycles in DRAIN and in simple mode -> d_o data stable, a/b ready low once r_mult holds a value, no beat lost or duplicated.
REQ-028 SHALL test saturation, simple mode, a=b=0x7FFFFFFF, shift 0: with macro -> 0x7FFFFFFF, sat_o=1; without macro -> 0x00000001, sat_o=0.
REQ-029 SHALL test clear_i after 2 of 4 products -> next cycle IDLE, cnt_o=0, busy_o=0; a following start with len=1, c=0, a=b=2 -> d=4.
REQ-030 SHALL test len=0, c=-7, shift 3 -> d=-7 with no a/b beat consumed.
